// File: rtl/sample_feeder_if.sv
// Handshake bundle between sample_feeder, its upstream sample source and the filter.
// The slave modport is the feeder's view; master is the view of whatever drives it.
interface sample_feeder_if;
    logic               sample_valid_in;
    logic signed [15:0] sample_in;
    logic               sample_ready_out;
    logic               filt_ready_out;
    logic signed [15:0] filt_sample_out;
    logic               filt_done_in;
    logic signed [15:0] filt_signal_in;
    logic               result_valid_out;
    logic signed [15:0] result_out;
    logic               busy_out;
    logic               overflow_out;
    logic               timeout_out;

    modport slave (
        input  sample_valid_in, sample_in, filt_done_in, filt_signal_in,
        output sample_ready_out, filt_ready_out, filt_sample_out,
               result_valid_out, result_out, busy_out, overflow_out, timeout_out
    );

    modport master (
        output sample_valid_in, sample_in, filt_done_in, filt_signal_in,
        input  sample_ready_out, filt_ready_out, filt_sample_out,
               result_valid_out, result_out, busy_out, overflow_out, timeout_out
    );
endinterface

// File: rtl/sample_feeder.sv
// Buffers upstream samples in a small FIFO and feeds them one at a time to a filter,
// capturing each result. Define SAMPLE_FEEDER_TIMEOUT_EN to add a WAIT-state timeout.
module sample_feeder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic           clk_in,
    input  logic           rst_in,
    sample_feeder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sample_feeder: FIFO_DEPTH must be a power of two in 2..16, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SETTLE} state_t;

    state_t             r_state, w_next;
    logic signed [15:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [AW:0]        r_count;
    logic signed [15:0] r_filt_sample, r_result;
    logic               r_result_valid, r_overflow;
    logic               w_full, w_empty, w_push, w_pop, w_timeout_hit;

    // Ready comes only from the registered count, so a pop never frees a slot same-cycle.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.sample_valid_in && !w_full;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop  = 1'b1;
                w_next = ISSUE;
            end
            ISSUE:  w_next = WAIT;
            WAIT:   if (bus.filt_done_in) w_next = SETTLE;
                    else if (w_timeout_hit) w_next = IDLE;
            SETTLE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr] <= bus.sample_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_filt_sample  <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr        <= r_rptr + 1'b1;
                r_filt_sample <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.sample_valid_in && w_full) r_overflow <= 1'b1;
            // filt_signal_in is valid during SETTLE, one cycle after done.
            r_result_valid <= (r_state == SETTLE);
            if (r_state == SETTLE) r_result <= bus.filt_signal_in;
        end
    end

`ifdef SAMPLE_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    // Counter is zero on the first WAIT cycle; hit marks the last allowed WAIT cycle.
    assign w_timeout_hit = (r_state == WAIT) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || r_state != WAIT) r_to_cnt <= '0;
        else                           r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)                                    r_timeout <= 1'b0;
        else if (w_timeout_hit && !bus.filt_done_in)   r_timeout <= 1'b1;
    end

    assign bus.timeout_out = r_timeout;
`else
    assign w_timeout_hit   = 1'b0;
    assign bus.timeout_out = 1'b0;
`endif

    assign bus.sample_ready_out = !w_full;
    assign bus.filt_ready_out   = (r_state == ISSUE);
    assign bus.filt_sample_out  = r_filt_sample;
    assign bus.result_valid_out = r_result_valid;
    assign bus.result_out       = r_result;
    assign bus.busy_out         = (r_state != IDLE);
    assign bus.overflow_out     = r_overflow;
endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: a byte-swapping filter model plus a scoreboard
// monitor that checks every filter strobe and every result against queued expectations.
module tb_sample_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nmis = 0;
    int   cyc  = 0;
    int   lat  = 32;
    bit   mute = 1'b0;
    logic m_done = 1'b0;
    logic s_done = 1'b0;
    int   t_done = 0;
    logic [15:0] q_smp[$];
    logic [15:0] q_res[$];

    sample_feeder_if bus();

    sample_feeder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(40)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.filt_done_in = m_done | s_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input logic [15:0] s, input logic [15:0] r, input bit has_r);
        q_smp.push_back(s);
        if (has_r) q_res.push_back(r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_filt_ready"},   32'(bus.filt_ready_out),           0);
        chk({tag, "_result_valid"}, 32'(bus.result_valid_out),         0);
        chk({tag, "_busy"},         32'(bus.busy_out),                 0);
        chk({tag, "_overflow"},     32'(bus.overflow_out),             0);
        chk({tag, "_timeout"},      32'(bus.timeout_out),              0);
        chk({tag, "_filt_sample"},  32'($unsigned(bus.filt_sample_out)), 0);
        chk({tag, "_result"},       32'($unsigned(bus.result_out)),    0);
        chk({tag, "_sample_ready"}, 32'(bus.sample_ready_out),         1);
    endtask

    task automatic push_one(input logic [15:0] v, output int tp);
        @(negedge clk);
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = v;
        tp = cyc;
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
    endtask

    task automatic wait_strobe(output int ts);
        bit seen = 1'b0;
        ts = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.filt_ready_out) begin
                seen = 1'b1;
                ts   = cyc;
            end
        end
        if (!seen) chk("strobe_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (q_res.size() == 0 && !bus.busy_out) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'(q_res.size()), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Filter model: done 'lat' cycles after the strobe, byte-swapped result the cycle after.
    initial begin
        logic [15:0] smp;
        bus.filt_signal_in = '0;
        forever begin
            @(negedge clk);
            if (bus.filt_ready_out && !mute) begin
                smp = bus.filt_sample_out;
                repeat (lat) @(negedge clk);
                m_done = 1'b1;
                t_done = cyc;
                @(negedge clk);
                m_done = 1'b0;
                bus.filt_signal_in = {smp[7:0], smp[15:8]};
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.filt_ready_out) begin
                if (q_smp.size() == 0) chk("unexpected_strobe", 32'($unsigned(bus.filt_sample_out)), 32'hdead);
                else chk("filt_sample", 32'($unsigned(bus.filt_sample_out)), 32'(q_smp.pop_front()));
            end
            if (bus.result_valid_out) begin
                if (q_res.size() == 0) chk("unexpected_result", 32'($unsigned(bus.result_out)), 32'hdead);
                else begin
                    chk("result", 32'($unsigned(bus.result_out)), 32'(q_res.pop_front()));
                    chk("done_to_valid", 32'(cyc - t_done), 2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int tp, ts, t2;
        logic [15:0] seq6 [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        logic [15:0] res5 [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
        logic [15:0] seq5 [5] = '{16'h0A0B, 16'h1122, 16'h3344, 16'h5566, 16'h7788};
        logic [15:0] rs5  [5] = '{16'h0B0A, 16'h2211, 16'h4433, 16'h6655, 16'h8877};
        bus.sample_valid_in = 1'b0;
        bus.sample_in       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Single sample, 32-cycle filter
        lat = 32;
        sb_push(16'h0100, 16'h0001, 1'b1);
        push_one(16'h0100, tp);
        wait_strobe(ts);
        chk("issue_latency", 32'(ts - tp), 2);
        wait_drain();

        // Six back-to-back pushes into a depth-4 FIFO
        lat = 3;
        for (int i = 0; i < 5; i++) sb_push(seq6[i], res5[i], 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) chk("ovf_before_6th", 32'(bus.overflow_out), 0);
            bus.sample_valid_in = 1'b1;
            bus.sample_in       = seq6[i];
        end
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
        chk("ovf_after_6th", 32'(bus.overflow_out), 1);
        wait_drain();
        chk("ovf_sticky", 32'(bus.overflow_out), 1);
        pulse_reset();

        // Full FIFO: push offered in the same cycle as the IDLE pop must be refused
        lat = 10;
        for (int i = 0; i < 5; i++) sb_push(seq5[i], rs5[i], 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.sample_valid_in = 1'b1;
            bus.sample_in       = seq5[i];
        end
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
        chk("full_ready", 32'(bus.sample_ready_out), 0);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (!bus.busy_out) hit = 1'b1;
            end
            chk("reach_idle_full", 32'(hit), 1);
        end
        chk("pop_cycle_ready", 32'(bus.sample_ready_out), 0);
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = 16'h0F0F;
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
        chk("refused_ovf", 32'(bus.overflow_out), 1);
        chk("after_pop_ready", 32'(bus.sample_ready_out), 1);
        wait_drain();
        pulse_reset();

        // Filter never completes
        mute = 1'b1;
        sb_push(16'h0303, 16'h0000, 1'b0);
        push_one(16'h0303, tp);
        wait_strobe(ts);
`ifdef SAMPLE_FEEDER_TIMEOUT_EN
        sb_push(16'h0403, 16'h0304, 1'b1);
        push_one(16'h0403, tp);
        while (cyc < ts + 40) @(negedge clk);
        chk("timeout_pre", 32'(bus.timeout_out), 0);
        @(negedge clk);
        chk("timeout_set", 32'(bus.timeout_out), 1);
        chk("timeout_idle", 32'(bus.busy_out), 0);
        mute = 1'b0;
        wait_strobe(t2);
        chk("next_issue", 32'(t2 - ts), 42);
        wait_drain();
        pulse_reset();
`else
        repeat (60) @(negedge clk);
        chk("no_timeout", 32'(bus.timeout_out), 0);
        chk("still_waiting", 32'(bus.busy_out), 1);
        pulse_reset();
        mute = 1'b0;
`endif

        // Reset 10 cycles into WAIT, filter completes afterwards
        lat = 20;
        sb_push(16'h0505, 16'h0000, 1'b0);
        push_one(16'h0505, tp);
        wait_strobe(ts);
        while (cyc < ts + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < ts + 24) @(negedge clk);
        chk_zero("abandon");

        // Stray done while IDLE
        @(negedge clk);
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_busy", 32'(bus.busy_out), 0);
            chk("stray_valid", 32'(bus.result_valid_out), 0);
        end

        chk("smp_queue_empty", 32'(q_smp.size()), 0);
        chk("res_queue_empty", 32'(q_res.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
